// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// State encoding, LSB size codes, IO region tag and grant bit positions.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IC_RD  = 2'd1,
        LSB_RD = 2'd2,
        LSB_WR = 2'd3
    } state_e;

    typedef enum logic {
        LAST_IC  = 1'b0,
        LAST_LSB = 1'b1
    } last_grant_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] IO_HI_DEF = 2'b11;

    localparam logic [2:0] IC_LEN = 3'd2;

    // bit positions inside the one-hot grant vector
    localparam int G_IC  = 0;
    localparam int G_LSB = 1;

    // size code 3 is illegal and is treated as a word
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and memory-pin bundle around mem_ctrl.
// slave: the controller side; master: ICache/LSB/RAM side.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ready;
    logic [15:0]       ic_data;

    logic              lsb_req;
    logic              lsb_we;
    logic [1:0]        lsb_size;
    logic [ADDR_W-1:0] lsb_addr;
    logic [31:0]       lsb_wdata;
    logic              lsb_ready;
    logic [31:0]       lsb_rdata;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport slave (
        input  ic_req, ic_addr, lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata, mem_din,
        output ic_ready, ic_data, lsb_ready, lsb_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output ic_req, ic_addr, lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata, mem_din,
        input  ic_ready, ic_data, lsb_ready, lsb_rdata, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl_arb.sv
// Two-requester round-robin arbiter: on a tie the requester not granted last wins.
// Grant is one-hot and only asserted while the controller is idle.
module mem_arb
    import mem_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_idle,
    input  logic       i_clear,
    input  logic       i_ic_req,
    input  logic       i_lsb_req,
    output logic [1:0] o_grant
);

    last_grant_e r_last;
    logic [1:0]  w_grant;

    always_comb begin
        w_grant = 2'b00;
        if (i_idle && !i_clear) begin
            case ({i_lsb_req, i_ic_req})
                2'b01:   w_grant[G_IC]  = 1'b1;
                2'b10:   w_grant[G_LSB] = 1'b1;
                2'b11: begin
                    if (r_last == LAST_IC) w_grant[G_LSB] = 1'b1;
                    else                   w_grant[G_IC]  = 1'b1;
                end
                default: w_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= LAST_IC;
        end else if (i_en && (w_grant != 2'b00)) begin
            r_last <= w_grant[G_LSB] ? LAST_LSB : LAST_IC;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port owner for ICache halfword fetches and LSB loads/stores.
// Optional MEM_CTRL_IO_STALL_EN holds IO-region store bytes while io_buffer_full is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_HI_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic clear_in,
    input  logic io_buffer_full,
    mem_ctrl_if.slave bus
);

    state_e            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic [2:0]        r_len, w_len_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic [ADDR_W-1:0] r_mem_a, w_mem_a_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [31:0]       r_buf, w_buf_nxt;
    logic [7:0]        r_dout, w_dout_nxt;
    logic              r_wr, w_wr_nxt;
    logic              r_ic_ready, w_ic_ready_nxt;
    logic              r_lsb_ready, w_lsb_ready_nxt;
    logic [15:0]       r_ic_data, w_ic_data_nxt;
    logic [31:0]       r_lsb_rdata, w_lsb_rdata_nxt;
    logic              r_paused;

    logic [1:0]        w_grant;
    logic              w_in_read;
    logic              w_stall;
    logic [1:0]        w_lane;
    logic [31:0]       w_merged;
    logic [7:0]        w_wbyte;

    mem_arb u_arb (
        .i_clk     (clk_in),
        .i_rst_n   (rst_in),
        .i_en      (rdy_in),
        .i_idle    (r_state == IDLE),
        .i_clear   (clear_in),
        .i_ic_req  (bus.ic_req),
        .i_lsb_req (bus.lsb_req),
        .o_grant   (w_grant)
    );

`ifdef MEM_CTRL_IO_STALL_EN
    assign w_stall = (r_state == LSB_WR) && r_wr && (r_mem_a[17:16] == IO_HI) && io_buffer_full;
`else
    logic w_unused_io_full;
    assign w_unused_io_full = io_buffer_full;
    assign w_stall          = 1'b0;
`endif

    assign w_in_read = (r_state == IC_RD) || (r_state == LSB_RD);
    // byte k arrives two edges after its address, so lane = cnt - 2
    assign w_lane    = r_cnt[1:0] - 2'd2;
    assign w_wbyte   = r_wdata[{r_cnt[1:0], 3'b000} +: 8];

    always_comb begin
        w_merged = r_buf;
        w_merged[{w_lane, 3'b000} +: 8] = bus.mem_din;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_len_nxt       = r_len;
        w_base_nxt      = r_base;
        w_mem_a_nxt     = r_mem_a;
        w_wdata_nxt     = r_wdata;
        w_buf_nxt       = r_buf;
        w_dout_nxt      = r_dout;
        w_wr_nxt        = r_wr;
        w_ic_ready_nxt  = 1'b0;
        w_lsb_ready_nxt = 1'b0;
        w_ic_data_nxt   = r_ic_data;
        w_lsb_rdata_nxt = r_lsb_rdata;

        case (r_state)
            IDLE: begin
                if (w_grant[G_IC]) begin
                    w_state_nxt = IC_RD;
                    w_len_nxt   = IC_LEN;
                    w_base_nxt  = bus.ic_addr;
                    w_mem_a_nxt = bus.ic_addr;
                    w_buf_nxt   = 32'h0;
                    w_cnt_nxt   = 3'd1;
                end else if (w_grant[G_LSB]) begin
                    w_state_nxt = bus.lsb_we ? LSB_WR : LSB_RD;
                    w_len_nxt   = size_bytes(bus.lsb_size);
                    w_base_nxt  = bus.lsb_addr;
                    w_mem_a_nxt = bus.lsb_addr;
                    w_wdata_nxt = bus.lsb_wdata;
                    w_dout_nxt  = bus.lsb_wdata[7:0];
                    w_wr_nxt    = bus.lsb_we;
                    w_buf_nxt   = 32'h0;
                    w_cnt_nxt   = 3'd1;
                end
            end

            IC_RD, LSB_RD: begin
                if (r_paused || clear_in) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    if (r_cnt < r_len) w_mem_a_nxt = r_base + ADDR_W'(r_cnt);
                    if (r_cnt >= 3'd2) w_buf_nxt = w_merged;
                    if (r_cnt == r_len + 3'd1) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 3'd0;
                        if (r_state == IC_RD) begin
                            w_ic_ready_nxt = 1'b1;
                            w_ic_data_nxt  = w_merged[15:0];
                        end else begin
                            w_lsb_ready_nxt = 1'b1;
                            w_lsb_rdata_nxt = w_merged;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end

            // stores ignore clear_in so a partial word never lands in memory
            LSB_WR: begin
                if (!w_stall) begin
                    if (r_cnt == r_len) begin
                        w_wr_nxt        = 1'b0;
                        w_lsb_ready_nxt = 1'b1;
                        w_state_nxt     = IDLE;
                        w_cnt_nxt       = 3'd0;
                    end else begin
                        w_mem_a_nxt = r_base + ADDR_W'(r_cnt);
                        w_dout_nxt  = w_wbyte;
                        w_wr_nxt    = 1'b1;
                        w_cnt_nxt   = r_cnt + 3'd1;
                    end
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_base      <= '0;
            r_mem_a     <= '0;
            r_wdata     <= 32'h0;
            r_buf       <= 32'h0;
            r_dout      <= 8'h0;
            r_wr        <= 1'b0;
            r_ic_ready  <= 1'b0;
            r_lsb_ready <= 1'b0;
            r_ic_data   <= 16'h0;
            r_lsb_rdata <= 32'h0;
            r_paused    <= 1'b0;
        end else if (rdy_in) begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_base      <= w_base_nxt;
            r_mem_a     <= w_mem_a_nxt;
            r_wdata     <= w_wdata_nxt;
            r_buf       <= w_buf_nxt;
            r_dout      <= w_dout_nxt;
            r_wr        <= w_wr_nxt;
            r_ic_ready  <= w_ic_ready_nxt;
            r_lsb_ready <= w_lsb_ready_nxt;
            r_ic_data   <= w_ic_data_nxt;
            r_lsb_rdata <= w_lsb_rdata_nxt;
            r_paused    <= 1'b0;
        end else if (w_in_read) begin
            // remembers that read data went stale during the pause
            r_paused <= 1'b1;
        end
    end

    assign bus.mem_a     = r_mem_a;
    assign bus.mem_dout  = r_dout;
    assign bus.mem_wr    = r_wr && rdy_in && !w_stall;
    assign bus.ic_ready  = r_ic_ready;
    assign bus.ic_data   = r_ic_data;
    assign bus.lsb_ready = r_lsb_ready;
    assign bus.lsb_rdata = r_lsb_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a synchronous byte RAM model and a ready-ordered scoreboard.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    typedef struct packed {
        logic        is_ic;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic clr = 1'b0;
    logic iofull = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int n_wr = 0;
    int cyc;
    int wr0;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [7:0] ram  [0:262143];
    logic [7:0] wram [0:262143];

    always #5 clk = ~clk;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .rdy_in         (rdy),
        .clear_in       (clr),
        .io_buffer_full (iofull),
        .bus            (bus)
    );

    // synchronous RAM: one-cycle read latency, writes logged separately
    always @(posedge clk) begin
        bus.mem_din <= ram[bus.mem_a[17:0]];
        if (bus.mem_wr === 1'b1) begin
            wram[bus.mem_a[17:0]] <= bus.mem_dout;
            n_wr <= n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic is_ic, input logic c, input logic [31:0] d);
        exp_t e;
        e.is_ic = is_ic;
        e.chk_data = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.ic_ready === 1'b1 || bus.lsb_ready === 1'b1) begin
            chk("ready_exclusive", 32'(bus.ic_ready & bus.lsb_ready), 32'h0);
            chk("sb_nonempty", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("ready_src", 32'(bus.ic_ready), 32'(mon_e.is_ic));
                if (mon_e.chk_data && mon_e.is_ic)  chk("ic_data", {16'h0, bus.ic_data}, mon_e.data);
                if (mon_e.chk_data && !mon_e.is_ic) chk("lsb_rdata", bus.lsb_rdata, mon_e.data);
            end
        end
    end

    task automatic wait_rdy(input bit want_ic, output int c);
        logic got;
        got = 1'b0;
        c = 0;
        while (!got && c < 40) begin
            @(negedge clk);
            c++;
            got = want_ic ? bus.ic_ready : bus.lsb_ready;
        end
        if (want_ic) chk("ic_ready_seen", 32'(got), 32'h1);
        else         chk("lsb_ready_seen", 32'(got), 32'h1);
    endtask

    task automatic ic_go(input logic [31:0] a);
        bus.ic_addr = a;
        bus.ic_req = 1'b1;
    endtask

    task automatic lsb_go(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        bus.lsb_we = we;
        bus.lsb_size = sz;
        bus.lsb_addr = a;
        bus.lsb_wdata = d;
        bus.lsb_req = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ic_req = 1'b0;
        bus.ic_addr = 32'h0;
        bus.lsb_req = 1'b0;
        bus.lsb_we = 1'b0;
        bus.lsb_size = SZ_B;
        bus.lsb_addr = 32'h0;
        bus.lsb_wdata = 32'h0;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h00;
        ram[18'h200] = 8'h78; ram[18'h201] = 8'h56;
        ram[18'h202] = 8'h34; ram[18'h203] = 8'h12;
        ram[18'h500] = 8'hCD; ram[18'h501] = 8'hAB;

        repeat (3) @(negedge clk);
        chk("rst_ic_ready", 32'(bus.ic_ready), 32'h0);
        chk("rst_lsb_ready", 32'(bus.lsb_ready), 32'h0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
        chk("rst_ic_data", 32'(bus.ic_data), 32'h0);
        chk("rst_lsb_rdata", bus.lsb_rdata, 32'h0);
        rst_n = 1'b1;

        // tie from reset: LSB, then ICache, then LSB again
        @(negedge clk);
        ic_go(32'h500);
        lsb_go(1'b0, SZ_W, 32'h200, 32'h0);
        push_exp(1'b0, 1'b1, 32'h12345678);
        push_exp(1'b1, 1'b1, 32'h0000ABCD);
        push_exp(1'b0, 1'b1, 32'h00000056);
        wait_rdy(1'b0, cyc);
        lsb_go(1'b0, SZ_B, 32'h201, 32'h0);
        wait_rdy(1'b1, cyc);
        bus.ic_req = 1'b0;
        wait_rdy(1'b0, cyc);
        bus.lsb_req = 1'b0;

        // ICache fetch latency and single pulse
        @(negedge clk);
        ic_go(32'h100);
        push_exp(1'b1, 1'b1, 32'h00000013);
        wait_rdy(1'b1, cyc);
        chk("ic_latency", cyc, 4);
        bus.ic_req = 1'b0;
        @(negedge clk);
        chk("ic_single_pulse", 32'(bus.ic_ready), 32'h0);

        // word read with address trace
        lsb_go(1'b0, SZ_W, 32'h200, 32'h0);
        push_exp(1'b0, 1'b1, 32'h12345678);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rd_addr_seq", bus.mem_a, 32'h200 + 32'(k));
        end
        wait_rdy(1'b0, cyc);
        chk("word_tail_latency", cyc, 2);
        bus.lsb_req = 1'b0;

        @(negedge clk);
        lsb_go(1'b0, SZ_B, 32'h203, 32'h0);
        push_exp(1'b0, 1'b1, 32'h00000012);
        wait_rdy(1'b0, cyc);
        bus.lsb_req = 1'b0;

        @(negedge clk);
        lsb_go(1'b0, SZ_H, 32'h201, 32'h0);
        push_exp(1'b0, 1'b1, 32'h00003456);
        wait_rdy(1'b0, cyc);
        bus.lsb_req = 1'b0;

        @(negedge clk);
        lsb_go(1'b0, 2'd3, 32'h200, 32'h0);
        push_exp(1'b0, 1'b1, 32'h12345678);
        wait_rdy(1'b0, cyc);
        bus.lsb_req = 1'b0;

        // clear during ICache read: no pulse, then a normal fetch
        @(negedge clk);
        ic_go(32'h100);
        @(negedge clk);
        clr = 1'b1;
        bus.ic_req = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        cyc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.ic_ready === 1'b1) cyc++;
        end
        chk("clear_no_ic_ready", cyc, 0);
        ic_go(32'h500);
        push_exp(1'b1, 1'b1, 32'h0000ABCD);
        wait_rdy(1'b1, cyc);
        chk("post_clear_latency", cyc, 4);
        bus.ic_req = 1'b0;

        // clear during word store must not abort it
        @(negedge clk);
        wr0 = n_wr;
        lsb_go(1'b1, SZ_W, 32'h300, 32'hDEADBEEF);
        push_exp(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        wait_rdy(1'b0, cyc);
        bus.lsb_req = 1'b0;
        chk("clr_wr_count", n_wr - wr0, 4);
        chk("clr_wr_data", {wram[18'h303], wram[18'h302], wram[18'h301], wram[18'h300]}, 32'hDEADBEEF);

        // pause mid-read: abandoned, then retried from scratch
        @(negedge clk);
        lsb_go(1'b0, SZ_W, 32'h200, 32'h0);
        push_exp(1'b0, 1'b1, 32'h12345678);
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("pause_mem_wr", 32'(bus.mem_wr), 32'h0);
        rdy = 1'b1;
        wait_rdy(1'b0, cyc);
        chk("pause_retry_latency", cyc, 7);
        bus.lsb_req = 1'b0;

        // IO store against a full UART buffer
        @(negedge clk);
        wr0 = n_wr;
        iofull = 1'b1;
        lsb_go(1'b1, SZ_B, 32'h30000, 32'h00000041);
        push_exp(1'b0, 1'b0, 32'h0);
`ifdef MEM_CTRL_IO_STALL_EN
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("io_stall_wr_low", 32'(bus.mem_wr), 32'h0);
        end
        iofull = 1'b0;
        #1;
        chk("io_resume_wr", 32'(bus.mem_wr), 32'h1);
        wait_rdy(1'b0, cyc);
        chk("io_ready_latency", cyc, 1);
`else
        @(negedge clk);
        chk("io_nostall_wr", 32'(bus.mem_wr), 32'h1);
        wait_rdy(1'b0, cyc);
        chk("io_ready_latency", cyc, 1);
        iofull = 1'b0;
`endif
        bus.lsb_req = 1'b0;
        chk("io_wr_count", n_wr - wr0, 1);
        chk("io_wr_data", 32'(wram[18'h30000]), 32'h41);

        // asynchronous reset in the middle of a store
        @(negedge clk);
        lsb_go(1'b1, SZ_W, 32'h400, 32'h11223344);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("rstw_mem_a", bus.mem_a, 32'h0);
        chk("rstw_mem_dout", 32'(bus.mem_dout), 32'h0);
        chk("rstw_ic_data", 32'(bus.ic_data), 32'h0);
        chk("rstw_lsb_rdata", bus.lsb_rdata, 32'h0);
        chk("rstw_readys", 32'({bus.ic_ready, bus.lsb_ready}), 32'h0);
        bus.lsb_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ic_go(32'h100);
        push_exp(1'b1, 1'b1, 32'h00000013);
        wait_rdy(1'b1, cyc);
        chk("post_reset_latency", cyc, 4);
        bus.ic_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

- Single owner of the byte-wide RAM/IO port.
- Arbitrates between two requesters:
  - the instruction cache, which fetches halfwords;
  - the load/store buffer, which issues byte, halfword or word reads and writes.
- Serialises each transaction into per-byte memory cycles and returns assembled data with a one-cycle ready pulse.
- Sits between the ICache/LSB and the top-level memory pins.

## Interface
Parameters:
- ADDR_W, 32, address width
- IO_HI, 2'b11, value of addr[17:16] identifying the IO region

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global pause, active-high
- clear_in  input  1  ROB misprediction clear
- ic_req  input  1  ICache request
- ic_addr  input  32  ICache halfword address
- ic_ready  output  1  one-cycle pulse, ic_data valid
- ic_data  output  16  fetched halfword, little-endian
- lsb_req  input  1  LSB request
- lsb_we  input  1  1 = write, 0 = read
- lsb_size  input  2  0 = 1 B, 1 = 2 B, 2 = 4 B (3 illegal, treated as 4 B)
- lsb_addr  input  32  LSB byte address
- lsb_wdata  input  32  store data, low bytes used
- lsb_ready  output  1  one-cycle pulse, read data valid or write done
- lsb_rdata  output  32  read data, zero-extended
- mem_din  input  8  RAM read byte
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  RAM write enable
- io_buffer_full  input  1  UART buffer full

## Operation
- States: IDLE, IC_RD, LSB_RD, LSB_WR. Byte counter cnt[2:0]. Length n: 2 for ICache; 1, 2 or 4 for LSB.
- IDLE arbitration:
  - Only one requester high: grant it.
  - Both high: grant whichever was not granted last (last_grant register; reset value = ICache, so LSB wins the first tie).
  - Requests are ignored while clear_in is high.
- Requesters hold req, address, size and wdata stable until their ready pulse. Inputs are latched at grant.
- Read:
  - Address A+k is driven for k = 0..n-1 on consecutive cycles.
  - Byte k is captured from mem_din two edges after its address edge, into byte lane k.
  - Unused lanes read 0.
- Write:
  - Byte k of wdata is driven with mem_a = A+k and mem_wr = 1 for n consecutive cycles.
  - mem_wr is then 0 and ready pulses.
- clear_in high at an edge:
  - IC_RD or LSB_RD go to IDLE with no ready pulse.
  - LSB_WR is not aborted and runs to completion (no partial stores).
- rdy_in low: all registers freeze.
  - mem_wr is forced to 0 combinationally.
  - An in-flight read is abandoned and the block returns to IDLE when rdy_in rises; the requester retries.
- Reset values: state = IDLE, mem_a = 0, mem_dout = 0, mem_wr = 0, ic_ready = 0, lsb_ready = 0, ic_data = 0, lsb_rdata = 0, cnt = 0.

## Timing
- Grant edge E0: mem_a <= A.
- Read of n bytes:
  - Byte k address at E(k), captured at E(k+2).
  - ready is high for one cycle after E(n+1).
  - ICache latency: 3 edges from grant to the ic_ready edge.
- Write of n bytes:
  - Bytes issued at E0..E(n-1).
  - At E(n): mem_wr <= 0 and lsb_ready <= 1.
- The next grant may occur at the edge after the ready pulse; there is no back-to-back overlap.
- ready outputs are never both high in the same cycle.
- Address arithmetic wraps modulo 2^32.

## Configuration
- MEM_CTRL_IO_STALL_EN defined:
  - Applies to any LSB_WR byte whose address has addr[17:16] == IO_HI.
  - While io_buffer_full is high, that byte is not issued: mem_wr = 0, cnt holds, then resumes.
- Undefined: io_buffer_full is ignored and writes never stall.

## Structure
- Package mem_ctrl_pkg:
  - state enum (IDLE, IC_RD, LSB_RD, LSB_WR);
  - size encodings SZ_B, SZ_H, SZ_W;
  - IO_HI default;
  - a size-to-byte-count function.
- Sub-module mem_arb: two-requester round-robin grant logic with the last_grant register. Outputs a one-hot grant valid only in IDLE.

## Test plan
- ICache read: ic_req, ic_addr = 0x100, RAM[0x100..0x101] = 0x13, 0x00 -> ic_ready is a single pulse 3 edges after grant, ic_data = 0x0013.
- LSB word read: lsb_addr = 0x200, RAM bytes = 0x78, 0x56, 0x34, 0x12 -> lsb_rdata = 0x12345678, mem_a sequence 0x200..0x203. LSB byte read -> lsb_rdata[31:8] = 0.
- Tie: both requesters high in IDLE with last_grant = ICache -> LSB is granted first, then ICache, on alternating grants.
- Clear: clear_in during IC_RD -> no ic_ready, block in IDLE. clear_in during a 4-byte LSB_WR -> all 4 bytes written, lsb_ready pulses.
- IO stall (macro on): store byte 0x41 to 0x30000 with io_buffer_full high for 5 cycles -> mem_wr stays 0 for those cycles, then one write cycle, then lsb_ready. With the macro off, the write issues immediately.
- Reset mid-write: rst_in low during LSB_WR -> mem_wr = 0 asynchronously, all outputs at reset values, state = IDLE.
